// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and ternary activation encodings for the psum accumulator
package conv_pkg;
  typedef enum logic {ACCUM, OUTPUT} state_t;
  localparam logic signed [1:0] TERN_POS = 2'sb01;
  localparam logic signed [1:0] TERN_ZERO = 2'sb00;
  localparam logic signed [1:0] TERN_NEG = 2'sb11;
endpackage

// File: rtl/conv_ternary_quant.sv
// conv_ternary_quant: combinational ternary quantizer of a signed accumulator against two thresholds
module conv_ternary_quant
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter logic signed [ACC_WIDTH-1:0] THRESH_POS = ACC_WIDTH'(4),
  parameter logic signed [ACC_WIDTH-1:0] THRESH_NEG = ACC_WIDTH'(-4)
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [1:0]           value
);
  assign value = acc >= THRESH_POS ? TERN_POS : acc <= THRESH_NEG ? TERN_NEG : TERN_ZERO;
endmodule

// File: rtl/conv_psum_accum.sv
// conv_psum_accum: accumulates NUM_CHANNELS psums per pixel, emits ternary result; PSUM_SATURATE_EN clamps on overflow instead of wrapping
module conv_psum_accum
  import conv_pkg::*;
#(
  parameter int CONVOLUTION_DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int NUM_CHANNELS = 4,
  parameter logic signed [ACC_WIDTH-1:0] THRESH_POS = ACC_WIDTH'(4),
  parameter logic signed [ACC_WIDTH-1:0] THRESH_NEG = ACC_WIDTH'(-4)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [CONVOLUTION_DATA_WIDTH-1:0] in_psum,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [1:0]                        out_value,
  output logic signed [ACC_WIDTH-1:0]              out_acc,
  output logic                                     ovf
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] chan_cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [1:0] q;
  logic sum_ovf, in_fire, out_fire, last;
  assign in_ready = state == ACCUM;
  assign out_valid = state == OUTPUT;
  assign out_acc = acc;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last = chan_cnt == CW'(NUM_CHANNELS - 1);
  assign sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(in_psum);
  assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
`ifdef PSUM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign acc_nxt = sum_ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
`else
  assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif
  conv_ternary_quant #(
    .ACC_WIDTH(ACC_WIDTH),
    .THRESH_POS(THRESH_POS),
    .THRESH_NEG(THRESH_NEG)
  ) u_quant (
    .acc(acc_nxt),
    .value(q)
  );
  always_comb state_nxt = (in_fire && last) ? OUTPUT : out_fire ? ACCUM : state;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ACCUM;
      acc <= '0;
      chan_cnt <= '0;
      out_value <= TERN_ZERO;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      ovf <= in_fire & sum_ovf;
      if (in_fire) begin
        acc <= acc_nxt;
        chan_cnt <= last ? '0 : chan_cnt + CW'(1);
        if (last) out_value <= q;
      end
      if (out_fire) begin
        acc <= '0;
        chan_cnt <= '0;
        out_value <= TERN_ZERO;
      end
    end
  end
endmodule
